// File: rtl/audio_sample_scheduler.sv
// Sample-rate scheduler for the audio PWM generator: buffers producer samples in a FIFO,
// releases one per sample tick with power-of-two volume scaling around midscale.
module audio_sample_scheduler #(
  parameter int unsigned CLK_DIV     = 12500,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned PRIME_LEVEL = 8,
  parameter logic [7:0]  MIDSCALE    = 8'h80
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  input  logic [1:0]                    volume,
  input  logic                          clr_underflow,
  output logic [7:0]                    music_data,
  output logic                          sample_tick,
  output logic                          playing,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE   = DW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   LVL_PRIME = (AW+1)'(PRIME_LEVEL);

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StPlay
  } state_t;

  // State and storage
  state_t          r_state;
  logic [DW-1:0]   r_div;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_level;
  logic [7:0]      r_music;
  logic            r_underflow;
  logic            r_playing;
  logic [7:0]      r_mem [FIFO_DEPTH];

  // Next-state and decode
  state_t          w_state_nxt;
  logic [DW-1:0]   w_div_nxt;
  logic [7:0]      w_music_nxt;
  logic            w_underflow_set;
  logic            w_flush;
  logic            w_tick;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic signed [8:0] w_diff;
  logic signed [8:0] w_atten;
  logic [7:0]      w_scaled;

  assign w_tick  = (r_state == StPlay) && (r_div == DIV_LAST);
  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == '0);

  // A full FIFO still accepts a write on a tick edge because the head leaves on that edge.
  assign wr_ready = (r_state != StIdle) && (!w_full || (w_tick && r_playing));
  assign w_push   = wr_valid && wr_ready && enable;
  assign w_pop    = w_tick && r_playing && !w_empty && enable;

  // Centre on midscale, arithmetic-shift attenuate, re-bias; range keeps the result in 8 bits.
  assign w_diff   = $signed({1'b0, r_mem[r_rd_ptr]}) - 9'sd128;
  assign w_atten  = w_diff >>> volume;
  assign w_scaled = 8'(w_atten + 9'sd128);

  always_comb begin
    w_state_nxt     = r_state;
    w_div_nxt       = r_div;
    w_music_nxt     = r_music;
    w_underflow_set = 1'b0;
    w_flush         = 1'b0;
    if (!enable) begin
      w_state_nxt = StIdle;
      w_div_nxt   = '0;
      w_music_nxt = MIDSCALE;
      w_flush     = 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_state_nxt = StPrime;
          w_div_nxt   = '0;
          w_music_nxt = MIDSCALE;
          w_flush     = 1'b1;
        end
        StPrime: begin
          w_div_nxt   = '0;
          w_music_nxt = MIDSCALE;
          if (r_level >= LVL_PRIME) begin
            w_state_nxt = StPlay;
          end
        end
        StPlay: begin
          if (w_tick) begin
            w_div_nxt = '0;
            if (w_empty) begin
              w_music_nxt     = MIDSCALE;
              w_underflow_set = 1'b1;
              w_state_nxt     = StPrime;
            end else begin
              w_music_nxt = w_scaled;
            end
          end else begin
            w_div_nxt = r_div + DIV_ONE;
          end
        end
        default: begin
          w_state_nxt = StIdle;
          w_div_nxt   = '0;
          w_music_nxt = MIDSCALE;
          w_flush     = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_div     <= '0;
      r_music   <= MIDSCALE;
      r_playing <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_music   <= w_music_nxt;
      r_playing <= (w_state_nxt == StPlay);
    end
  end

  // Sticky flag; a new underflow outranks a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_underflow <= 1'b0;
    end else if (w_underflow_set) begin
      r_underflow <= 1'b1;
    end else if (clr_underflow) begin
      r_underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LVL_ONE;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LVL_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  assign music_data  = r_music;
  assign sample_tick = w_tick;
  assign playing     = r_playing;
  assign underflow   = r_underflow;
  assign fifo_level  = r_level;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Self-checking bench for audio_sample_scheduler: queue-based reference model compared every
// cycle, plus directed literal expectations.
module tb_audio_sample_scheduler;

  localparam int CDIV  = 4;
  localparam int DEPTH = 16;
  localparam int PRIME = 2;
  localparam logic [7:0] MID = 8'h80;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic [1:0] volume = 2'd0;
  logic       clr_underflow = 1'b0;
  logic [7:0] music_data;
  logic       sample_tick;
  logic       playing;
  logic       underflow;
  logic [4:0] fifo_level;

  audio_sample_scheduler #(
    .CLK_DIV    (CDIV),
    .FIFO_DEPTH (DEPTH),
    .PRIME_LEVEL(PRIME),
    .MIDSCALE   (MID)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .volume       (volume),
    .clr_underflow(clr_underflow),
    .music_data   (music_data),
    .sample_tick  (sample_tick),
    .playing      (playing),
    .underflow    (underflow),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 priming, 2 playing; queue holds buffered samples.
  int         m_mode = 0;
  int         m_phase = 0;
  logic [7:0] m_music = 8'h80;
  logic       m_under = 1'b0;
  logic [7:0] m_q[$];
  bit         t_tick, t_rdy, t_push, t_set;
  logic [7:0] t_head;

  function automatic logic [7:0] scale(input logic [7:0] s, input logic [1:0] v);
    int d;
    d = int'(s) - 128;
    d = d >>> v;
    return 8'(d + 128);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_phase = 0; m_music = MID; m_under = 1'b0; m_q.delete();
    end else begin
      t_tick = (m_mode == 2) && (m_phase == CDIV - 1);
      t_rdy  = (m_mode != 0) && ((m_q.size() < DEPTH) || t_tick);
      t_push = wr_valid && t_rdy && enable;
      t_set  = 1'b0;
      if (!enable) begin
        m_mode = 0; m_phase = 0; m_music = MID; m_q.delete();
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (m_q.size() >= PRIME) begin
          m_mode = 2; m_phase = 0;
        end
        if (t_push) m_q.push_back(wr_data);
      end else begin
        if (t_tick) begin
          m_phase = 0;
          if (m_q.size() > 0) begin
            t_head  = m_q.pop_front();
            m_music = scale(t_head, volume);
          end else begin
            m_music = MID; t_set = 1'b1; m_mode = 1;
          end
        end else begin
          m_phase++;
        end
        if (t_push) m_q.push_back(wr_data);
      end
      m_under = t_set ? 1'b1 : (clr_underflow ? 1'b0 : m_under);
    end
  end

  bit cmp_on = 1'b0;
  always @(negedge clk) begin
    if (reset && cmp_on) begin
      check("music_data", music_data, m_music);
      check("sample_tick", sample_tick, (m_mode == 2 && m_phase == CDIV - 1));
      check("playing", playing, (m_mode == 2));
      check("underflow", underflow, m_under);
      check("fifo_level", fifo_level, m_q.size());
      check("wr_ready", wr_ready,
            (m_mode != 0) && (m_q.size() < DEPTH || (m_mode == 2 && m_phase == CDIV - 1)));
    end
  end

  // Producer: drains tx_q through the valid/ready handshake.
  logic [7:0] tx_q[$];
  bit         acc = 1'b0;
  always @(negedge clk) acc = wr_valid && wr_ready && enable && reset;
  always @(posedge clk) begin
    if (acc && tx_q.size() > 0) void'(tx_q.pop_front());
    #1;
    wr_valid = (tx_q.size() > 0);
    wr_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
  end

  // Captures music_data after every pop for the in-order streaming check.
  bit         mon_on = 1'b0;
  bit         prev_pop = 1'b0;
  logic [7:0] got_q[$];
  always @(negedge clk) begin
    if (mon_on && prev_pop) got_q.push_back(music_data);
    prev_pop = sample_tick && playing && (fifo_level != 0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 64; i++) begin
      if (sample_tick) return;
      cyc();
    end
    check("wait_tick_timeout", 0, 1);
  endtask

  task automatic wait_playing();
    for (int i = 0; i < 64; i++) begin
      if (playing) return;
      cyc();
    end
    check("wait_playing_timeout", 0, 1);
  endtask

  task automatic tick_and_check(input string name, input logic [7:0] exp);
    wait_tick();
    cyc();
    check(name, music_data, exp);
  endtask

  logic [7:0] exp_stream[$];
  bit         found;

  initial begin
    #1 reset = 1'b0;
    enable = 1'b1;
    tx_q = '{8'h10, 8'hF0, 8'h80, 8'hFF, 8'h00, 8'h80, 8'hFF, 8'h00, 8'h80};
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    cmp_on = 1'b1;
    check("rst_music", music_data, 8'h80);
    check("rst_level", fifo_level, 0);
    check("rst_ready", wr_ready, 0);
    check("rst_playing", playing, 0);
    check("rst_tick", sample_tick, 0);
    check("rst_underflow", underflow, 0);

    // 1: prime at two entries, first tick four cycles after entry
    wait_playing();
    check("t1_level_at_play", fifo_level, 3);
    cyc(); cyc(); cyc();
    check("t1_first_tick", sample_tick, 1);
    cyc();
    check("t1_music_10", music_data, 8'h10);
    tick_and_check("t1_music_F0", 8'hF0);
    tick_and_check("t1_music_80", 8'h80);

    // 2: volume scaling
    volume = 2'd1;
    tick_and_check("t2_v1_FF", 8'hBF);
    tick_and_check("t2_v1_00", 8'h40);
    tick_and_check("t2_v1_80", 8'h80);
    volume = 2'd3;
    tick_and_check("t2_v3_FF", 8'h8F);
    tick_and_check("t2_v3_00", 8'h70);
    tick_and_check("t2_v3_80", 8'h80);
    volume = 2'd0;

    // 3: underflow, clear, and set-beats-clear
    tick_and_check("t3_uf_music", 8'h80);
    check("t3_uf_flag", underflow, 1);
    check("t3_uf_playing", playing, 0);
    clr_underflow = 1'b1;
    cyc();
    clr_underflow = 1'b0;
    check("t3_cleared", underflow, 0);
    tx_q = '{8'h20, 8'hE0};
    wait_playing();
    tick_and_check("t3_music_20", 8'h20);
    tick_and_check("t3_music_E0", 8'hE0);
    wait_tick();
    clr_underflow = 1'b1;
    cyc();
    clr_underflow = 1'b0;
    check("t3_set_wins", underflow, 1);
    check("t3_playing_off", playing, 0);
    check("t3_music_mid", music_data, 8'h80);

    // 4: fill to full, push-on-pop while full, 40-sample ordered stream
    mon_on = 1'b1;
    got_q.delete();
    exp_stream.delete();
    for (int i = 0; i < 40; i++) begin
      exp_stream.push_back(8'(i * 37 + 5));
      tx_q.push_back(8'(i * 37 + 5));
    end
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (fifo_level == 5'd16 && !sample_tick) found = 1'b1;
      else cyc();
    end
    check("t4_reached_full", found, 1);
    check("t4_full_ready", wr_ready, 0);
    check("t4_full_level", fifo_level, 16);
    wait_tick();
    check("t4_tick_ready", wr_ready, 1);
    cyc();
    check("t4_level_stays", fifo_level, 16);
    for (int i = 0; i < 400 && got_q.size() < 40; i++) cyc();
    check("t4_stream_count", got_q.size(), 40);
    for (int i = 0; i < 40 && i < got_q.size(); i++) check("t4_stream_order", got_q[i], exp_stream[i]);
    mon_on = 1'b0;

    // 5: stop with five queued, then a full re-prime is needed
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (playing && fifo_level == 5'd5 && tx_q.size() == 0) found = 1'b1;
      else cyc();
    end
    check("t5_five_queued", found, 1);
    enable = 1'b0;
    cyc();
    check("t5_level_flushed", fifo_level, 0);
    check("t5_music_mid", music_data, 8'h80);
    check("t5_ready_low", wr_ready, 0);
    check("t5_playing_low", playing, 0);
    enable = 1'b1;
    cyc(); cyc(); cyc();
    check("t5_no_replay", playing, 0);
    check("t5_still_empty", fifo_level, 0);
    tx_q = '{8'h30, 8'h40, 8'h50};
    wait_playing();

    // 6: asynchronous reset mid-cycle during PLAY
    #1;
    reset = 1'b0;
    tx_q.delete();
    #1;
    check("t6_music", music_data, 8'h80);
    check("t6_playing", playing, 0);
    check("t6_underflow", underflow, 0);
    check("t6_level", fifo_level, 0);
    check("t6_ready", wr_ready, 0);
    check("t6_tick", sample_tick, 0);
    cyc(); cyc();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_sample_scheduler.md
Name: audio_sample_scheduler

Overview:
Sample-rate scheduler and buffer feeding the 8-bit music_data input of the on-board audio PWM generator. A producer (GPIO/processor song logic) pushes 8-bit unsigned samples into a small FIFO through a valid/ready handshake. The block releases one sample per sample-rate tick, applies a power-of-two volume scaling around midscale, and handles priming, underflow and stop.

Parameters:
CLK_DIV, 12500, clk cycles per sample tick (100 MHz / 8 kHz); legal range >= 2.
FIFO_DEPTH, 16, sample FIFO entries; power of two, 4 to 64.
PRIME_LEVEL, 8, FIFO fill level required before playback starts; range 1 to FIFO_DEPTH.
MIDSCALE, 8'h80, silence level driven whenever no sample is playing.

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-low reset (0 = reset)
enable  input  1  1 = run playback; 0 = stop and flush
wr_valid  input  1  producer has a sample on wr_data
wr_data  input  8  unsigned audio sample
wr_ready  output  1  FIFO can accept; a transfer occurs when wr_valid & wr_ready at a clk edge
volume  input  2  attenuation shift: 0 = full, 3 = 1/8
clr_underflow  input  1  single-cycle pulse that clears underflow
music_data  output  8  sample to the PWM generator
sample_tick  output  1  one-cycle pulse on every sample period while running
playing  output  1  1 while in PLAY
underflow  output  1  sticky: FIFO was empty at a PLAY tick
fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync deassert handled externally) drives: state IDLE, FIFO empty, divider 0, music_data = MIDSCALE, sample_tick 0, playing 0, underflow 0, fifo_level 0, wr_ready 0.
- States:
  - IDLE: FIFO held empty, wr_ready 0, divider held at 0, music_data = MIDSCALE. Goes to PRIME when enable = 1.
  - PRIME: wr_ready = !full, divider held at 0, music_data = MIDSCALE. Goes to PLAY on the edge where fifo_level >= PRIME_LEVEL.
  - PLAY: divider counts 0..CLK_DIV-1 and wraps. sample_tick = 1 for exactly the cycle where the count is CLK_DIV-1.
- Tick in PLAY:
  - FIFO non-empty: pop the head; music_data takes the scaled value on the next edge (one-cycle latency from sample_tick).
  - FIFO empty: music_data <= MIDSCALE, underflow <= 1, state -> PRIME, divider cleared.
- The first tick after entering PLAY occurs CLK_DIV cycles after entry.
- enable = 0 in any state: on the next edge go to IDLE, flush the FIFO, drive music_data = MIDSCALE, playing 0. Any in-flight write on that edge is dropped.
- Scaling: d = {1'b0,sample} - 9'd128 as signed 9-bit; m = d >>> volume (arithmetic shift); music_data = m + 128, truncated to 8 bits. The result never overflows. volume is sampled on the pop cycle.
- FIFO:
  - wr_ready is combinational from occupancy: !full and state != IDLE.
  - Simultaneous push and pop leaves the level unchanged. When full, a push is accepted only if a pop occurs on the same edge: wr_ready = !full | pop_this_cycle, with pop_this_cycle = sample_tick & playing.
  - Pointers wrap modulo FIFO_DEPTH.
- underflow is sticky until clr_underflow. If set and clear occur on the same edge, set wins.
- playing = (state == PLAY), registered.

Test Plan:
1. Use CLK_DIV = 4, PRIME_LEVEL = 2. Release reset with enable = 1, push 8'h10, 8'hF0, 8'h80 → PLAY after the 2nd push. The first tick follows 4 cycles later. music_data = 10, F0, 80 on consecutive ticks, each one cycle after sample_tick.
2. volume = 1, samples 8'hFF, 8'h00, 8'h80 → music_data 8'hBF, 8'h40, 8'h80. With volume = 3 → 8'h8F, 8'h70, 8'h80.
3. Push only PRIME_LEVEL samples and hold wr_valid low → after they play, the next tick gives music_data 8'h80, underflow = 1, playing = 0, state PRIME. A clr_underflow pulse clears the flag; clr_underflow on the same cycle as a new underflow leaves it at 1.
4. Fill to FIFO_DEPTH = 16 → wr_ready = 0 and fifo_level = 16. On a tick cycle with wr_valid = 1, wr_ready = 1 and the level stays 16. Verify pointer wrap by streaming 40 samples in order with no loss.
5. Deassert enable mid-PLAY with 5 samples queued → next edge fifo_level = 0, music_data = 8'h80, wr_ready = 0. Re-enabling requires a full re-prime.
6. Assert reset asynchronously mid-cycle during PLAY → all outputs take their reset values immediately, without waiting for a clk edge.
